// File: rtl/ascii_operand_loader_pkg.sv
// Shared definitions for the ASCII operand loader: FSM state codes,
// ASCII character constants and character-class helpers.
package loader_pkg;

  localparam logic [3:0] X_TENS  = 4'd0;
  localparam logic [3:0] X_ONES  = 4'd1;
  localparam logic [3:0] X_TERM  = 4'd2;
  localparam logic [3:0] Y_TENS  = 4'd3;
  localparam logic [3:0] Y_ONES  = 4'd4;
  localparam logic [3:0] Y_TERM  = 4'd5;
  localparam logic [3:0] OP      = 4'd6;
  localparam logic [3:0] OP_TERM = 4'd7;
  localparam logic [3:0] HOLD    = 4'd8;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == CH_LF) || (c == CH_CR) || (c == CH_SP);
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == CH_PLUS) || (c == CH_MINUS);
  endfunction

endpackage

// File: rtl/ascii_operand_loader_if.sv
// Character-stream input and operand-set output handshakes of the loader.
// master = stream source / operand sink, slave = the loader itself.
interface ascii_operand_loader_if #(
  parameter int DW = 5,
  parameter int CW = 8
);

  logic [CW-1:0] ch_data;
  logic          ch_valid;
  logic          ch_ready;
  logic [DW-1:0] x_out;
  logic [DW-1:0] y_out;
  logic          sub_out;
  logic          op_valid;
  logic          op_ready;

  modport master (
    output ch_data, ch_valid, op_ready,
    input  ch_ready, x_out, y_out, sub_out, op_valid
  );

  modport slave (
    input  ch_data, ch_valid, op_ready,
    output ch_ready, x_out, y_out, sub_out, op_valid
  );

endinterface

// File: rtl/ascii_operand_loader_digit_pair_acc.sv
// Converts a tens/ones ASCII digit pair to a 7-bit value (0..99) and flags
// whether both are digits and whether the value fits in DW bits.
module digit_pair_acc
  import loader_pkg::*;
#(
  parameter int DW = 5
) (
  input  logic [7:0] i_tens_ch,
  input  logic [7:0] i_ones_ch,
  output logic [6:0] o_value,
  output logic       o_is_digit,
  output logic       o_in_range
);

  localparam logic [6:0] MAX_VAL = 7'((1 << DW) - 1);

  // Low nibble of '0'..'9' is the digit value itself.
  assign o_value    = 7'(i_tens_ch[3:0]) * 7'd10 + 7'(i_ones_ch[3:0]);
  assign o_is_digit = is_digit(i_tens_ch) && is_digit(i_ones_ch);
  assign o_in_range = o_is_digit && (o_value <= MAX_VAL);

endmodule

// File: rtl/ascii_operand_loader.sv
// Parses "DD T DD T P T" ASCII commands into X/Y operands and an add/sub flag.
// Optional error counter enabled with LOADER_ERRCNT_EN.
module ascii_operand_loader
  import loader_pkg::*;
#(
  parameter int DW = 5,
  parameter int CW = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  ascii_operand_loader_if.slave         bus,
`ifdef LOADER_ERRCNT_EN
  output logic [7:0]                    err_cnt,
  input  logic                          err_clr,
`endif
  output logic                          err
);

  logic [3:0]    r_state;
  logic [3:0]    w_state_nxt;
  logic [7:0]    r_tens_ch;
  logic [DW-1:0] r_x_stg;
  logic [DW-1:0] r_y_stg;
  logic          r_sub_stg;
  logic [DW-1:0] r_x_out;
  logic [DW-1:0] r_y_out;
  logic          r_sub_out;
  logic          r_err;

  logic [CW-1:0] w_ch_raw;
  logic [7:0]    w_ch;
  logic          w_ready;
  logic          w_accept;
  logic          w_bad;
  logic [6:0]    w_val;
  logic          w_pair_digit;
  logic          w_pair_ok;

  assign w_ch_raw = bus.ch_data;
  assign w_ch     = w_ch_raw[7:0];
  assign w_ready  = (r_state != HOLD);
  assign w_accept = bus.ch_valid && w_ready;

  digit_pair_acc #(.DW(DW)) u_pair (
    .i_tens_ch  (r_tens_ch),
    .i_ones_ch  (w_ch),
    .o_value    (w_val),
    .o_is_digit (w_pair_digit),
    .o_in_range (w_pair_ok)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_bad       = 1'b0;
    if (w_accept) begin
      case (r_state)
        X_TENS: begin
          if (is_digit(w_ch))     w_state_nxt = X_ONES;
          else if (!is_term(w_ch)) w_bad = 1'b1;
        end
        X_ONES:  if (w_pair_digit && w_pair_ok) w_state_nxt = X_TERM;  else w_bad = 1'b1;
        X_TERM:  if (is_term(w_ch))             w_state_nxt = Y_TENS;  else w_bad = 1'b1;
        Y_TENS:  if (is_digit(w_ch))            w_state_nxt = Y_ONES;  else w_bad = 1'b1;
        Y_ONES:  if (w_pair_digit && w_pair_ok) w_state_nxt = Y_TERM;  else w_bad = 1'b1;
        Y_TERM:  if (is_term(w_ch))             w_state_nxt = OP;      else w_bad = 1'b1;
        OP:      if (is_op(w_ch))               w_state_nxt = OP_TERM; else w_bad = 1'b1;
        OP_TERM: if (is_term(w_ch))             w_state_nxt = HOLD;    else w_bad = 1'b1;
        default: w_state_nxt = X_TENS;
      endcase
    end
    if (w_bad) w_state_nxt = X_TENS;
    if ((r_state == HOLD) && bus.op_ready) w_state_nxt = X_TENS;
  end

  // Partial results live in staging registers so a malformed command never
  // disturbs the last completed operand set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= X_TENS;
      r_tens_ch <= '0;
      r_x_stg   <= '0;
      r_y_stg   <= '0;
      r_sub_stg <= 1'b0;
      r_x_out   <= '0;
      r_y_out   <= '0;
      r_sub_out <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_bad;
      if (w_accept && !w_bad) begin
        case (r_state)
          X_TENS, Y_TENS: if (is_digit(w_ch)) r_tens_ch <= w_ch;
          X_ONES:  r_x_stg   <= DW'(w_val);
          Y_ONES:  r_y_stg   <= DW'(w_val);
          OP:      r_sub_stg <= (w_ch == CH_MINUS);
          OP_TERM: begin
            r_x_out   <= r_x_stg;
            r_y_out   <= r_y_stg;
            r_sub_out <= r_sub_stg;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ch_ready = w_ready;
  assign bus.op_valid = (r_state == HOLD);
  assign bus.x_out    = r_x_out;
  assign bus.y_out    = r_y_out;
  assign bus.sub_out  = r_sub_out;
  assign err          = r_err;

`ifdef LOADER_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Clear wins over a coincident error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_err_cnt <= '0;
    else if (err_clr)                      r_err_cnt <= '0;
    else if (r_err && (r_err_cnt != '1))   r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_ascii_operand_loader.sv
// Scoreboard bench for ascii_operand_loader: expected operand sets are queued
// when a command is streamed and compared when the loader hands them off.
module tb_ascii_operand_loader;

  localparam int DW = 5;

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic          sub;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
`ifdef LOADER_ERRCNT_EN
  logic [7:0] err_cnt;
  logic       err_clr = 1'b0;
`endif

  ascii_operand_loader_if #(.DW(DW), .CW(8)) bus ();

  ascii_operand_loader #(.DW(DW), .CW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
`ifdef LOADER_ERRCNT_EN
    .err_cnt (err_cnt),
    .err_clr (err_clr),
`endif
    .err     (err)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drives one character and returns err as seen in the cycle after accept.
  task automatic send_char(input byte c, output logic err_o);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.ch_data  = c;
    bus.ch_valid = 1'b1;
    @(negedge clk);
    while (!bus.ch_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ch_ready) begin
      check_eq("ch_ready_timeout", int'(bus.ch_ready), 1);
      bus.ch_valid = 1'b0;
      err_o = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.ch_valid = 1'b0;
    err_o = err;
  endtask

  task automatic send_chk(input byte c, input logic exp_err, input string tag);
    logic e;
    send_char(c, e);
    check_eq(tag, int'(e), int'(exp_err));
  endtask

  task automatic send_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) send_chk(s[i], 1'b0, tag);
  endtask

  task automatic send_cmd(input string s, input int x, input int y, input logic sub);
    exp_t e;
    e.x = DW'(x);
    e.y = DW'(y);
    e.sub = sub;
    sb_q.push_back(e);
    send_str(s, "cmd_err");
    check_eq("lat_op_valid", int'(bus.op_valid), 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.op_valid && bus.op_ready) begin
      check_eq("op_pending", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_eq("op_x",   int'(bus.x_out),   int'(mon_e.x));
        check_eq("op_y",   int'(bus.y_out),   int'(mon_e.y));
        check_eq("op_sub", int'(bus.sub_out), int'(mon_e.sub));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ch_valid = 1'b0;
    bus.ch_data  = '0;
    bus.op_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_op_valid", int'(bus.op_valid), 0);
    check_eq("rst_x",        int'(bus.x_out),    0);
    check_eq("rst_y",        int'(bus.y_out),    0);
    check_eq("rst_sub",      int'(bus.sub_out),  0);
    check_eq("rst_err",      int'(err),          0);
    check_eq("rst_ch_ready", int'(bus.ch_ready), 1);
    rst = 1'b0;

    // Plain add with op_ready held high.
    send_cmd("12\n07\n+\n", 12, 7, 1'b0);
    wait_drain();
    @(posedge clk); #1;
    check_eq("t1_op_drop", int'(bus.op_valid), 0);
    check_eq("t1_x_keep",  int'(bus.x_out),    12);

    // Back-pressure: outputs held stable while op_ready is low.
    bus.op_ready = 1'b0;
    send_cmd("31\n31\n-\n", 31, 31, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t2_hold_valid", int'(bus.op_valid), 1);
      check_eq("t2_hold_x",     int'(bus.x_out),    31);
      check_eq("t2_hold_y",     int'(bus.y_out),    31);
      check_eq("t2_hold_sub",   int'(bus.sub_out),  1);
      check_eq("t2_hold_rdy",   int'(bus.ch_ready), 0);
    end
    @(posedge clk); #1;
    bus.op_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t2_op_drop", int'(bus.op_valid), 0);
    check_eq("t2_q_empty", sb_q.size(),         0);

    // Out-of-range operand, then recovery.
    send_chk("4", 1'b0, "t3_err_4");
    send_chk("5", 1'b1, "t3_err_45");
    @(posedge clk); #1;
    check_eq("t3_err_pulse", int'(err), 0);
    send_str("3", "t3_err_3");
    send_chk("2", 1'b1, "t3_err_32");
    send_cmd("03\n09\n+\n", 3, 9, 1'b0);
    wait_drain();

    // Illegal characters; last completed values retained.
    send_chk("1", 1'b0, "t4_err_1");
    send_chk("a", 1'b1, "t4_err_a");
    check_eq("t4_x_keep", int'(bus.x_out), 3);
    send_str("\r\n02\n02\n", "t4_err_pre");
    send_chk("*", 1'b1, "t4_err_star");
    check_eq("t4_no_valid", int'(bus.op_valid), 0);
    check_eq("t4_y_keep",   int'(bus.y_out),    9);
    check_eq("t4_sub_keep", int'(bus.sub_out),  0);

    // Space terminators and boundary values.
    send_cmd("00 31 - ", 0, 31, 1'b1);
    wait_drain();

    // Reset mid-command.
    send_str("12\n0", "t5_err_pre");
    rst = 1'b1;
    #1;
    check_eq("t5_rst_x",     int'(bus.x_out),    0);
    check_eq("t5_rst_y",     int'(bus.y_out),    0);
    check_eq("t5_rst_sub",   int'(bus.sub_out),  0);
    check_eq("t5_rst_valid", int'(bus.op_valid), 0);
    check_eq("t5_rst_rdy",   int'(bus.ch_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    send_cmd("05\n06\n+\n", 5, 6, 1'b0);
    wait_drain();
    check_eq("t5_x_final", int'(bus.x_out), 5);
    check_eq("t5_y_final", int'(bus.y_out), 6);

`ifdef LOADER_ERRCNT_EN
    for (int i = 0; i < 300; i++) send_chk("z", 1'b1, "t6_err_z");
    @(posedge clk); #1;
    check_eq("t6_cnt_sat", int'(err_cnt), 255);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check_eq("t6_cnt_clr", int'(err_cnt), 0);
    send_chk("z", 1'b1, "t6_err_z2");
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check_eq("t6_cnt_clr_win", int'(err_cnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
